// File: rtl/stream_fc_pkg.sv
// stream_fc_pkg: shared types and helpers for the streaming fully-connected engine.
//   state_e     - engine FSM state encoding
//   clog2_min1  - clog2 that never yields a zero-width field
//   ceil_div    - integer ceiling division (pass count)
//   saturate    - clamp a signed value to a w-bit two's-complement range
package stream_fc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMac,
        StDrain,
        StStore,
        StArgmax,
        StOut
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned     w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/stream_fc_mac_lane.sv
// stream_fc_mac_lane: one multiply-accumulate lane of the FC engine.
//   clk, rst_n  - clock, asynchronous active-low reset
//   init        - load acc with (bias << FRAC_BITS) + x*w (first product of a pass)
//   acc_en      - acc += x*w
//   bias, x, w  - signed DATA_W operands
//   score       - acc >> FRAC_BITS reduced to DATA_W (saturated when STREAM_FC_SAT_EN
//                 is defined, otherwise wrapped)
module stream_fc_mac_lane
    import stream_fc_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 11,
    parameter int unsigned ACC_W     = 34
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] bias,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [DATA_W-1:0] score
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    shifted;

    assign prod     = x * w;
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias};

    always_comb begin
        acc_d = acc_q;
        if (init) begin
            acc_d = (bias_ext <<< FRAC_BITS) + prod_ext;
        end else if (acc_en) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign shifted = acc_q >>> FRAC_BITS;

`ifdef STREAM_FC_SAT_EN
    assign score = DATA_W'(saturate(64'(shifted), DATA_W));
`else
    assign score = DATA_W'(shifted);
`endif

endmodule

// File: rtl/stream_fc_engine.sv
// stream_fc_engine: streaming fully-connected layer with argmax output.
// Buffers one frame of N_IN samples, computes N_OUT neuron scores in
// ceil(N_OUT/LANES) passes of LANES parallel MACs, then emits the argmax class.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last - input sample stream
//   w_addr/w_data               - weight ROM (data one cycle after address)
//   b_addr/b_data               - bias ROM (same packing and latency)
//   m_valid/m_ready/m_class     - argmax result handshake
//   frame_err                   - frame length differed from N_IN
// Optional macro STREAM_FC_SAT_EN: saturate scores instead of wrapping.
module stream_fc_engine
    import stream_fc_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 11,
    parameter int unsigned N_IN      = 784,
    parameter int unsigned N_OUT     = 10,
    parameter int unsigned LANES     = 4,
    localparam int unsigned P        = ceil_div(N_OUT, LANES),
    localparam int unsigned AW       = clog2_min1(P * N_IN),
    localparam int unsigned BW       = clog2_min1(P),
    localparam int unsigned CW       = clog2_min1(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_last,
    output logic [AW-1:0]           w_addr,
    input  logic [LANES*DATA_W-1:0] w_data,
    output logic [BW-1:0]           b_addr,
    input  logic [LANES*DATA_W-1:0] b_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CW-1:0]           m_class,
    output logic                    frame_err
);

    localparam int unsigned ACC_W = 2 * DATA_W + clog2_min1(N_IN);
    localparam int unsigned CNT_W = clog2_min1(((N_IN > N_OUT) ? N_IN : N_OUT) + 1);
    localparam logic [CNT_W-1:0] LAST_J = CNT_W'(N_IN - 1);
    localparam bit MULTI_IN = (N_IN > 1);

    // Async assert, synchronous release.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          n_valid_q;
    logic                      discard_q;
    logic                      s_ready_q;
    logic                      m_valid_q;
    logic [CW-1:0]             m_class_q;
    logic                      frame_err_q;
    logic [AW-1:0]             w_addr_q;
    logic [BW-1:0]             b_addr_q;
    logic signed [DATA_W-1:0]  x_q;
    logic signed [DATA_W-1:0]  x_sel;
    logic signed [DATA_W-1:0]  best_val_q;
    logic [CW-1:0]             best_idx_q;
    logic signed [DATA_W-1:0]  arg_val;
    logic                      hs;
    logic                      lane_init;
    logic                      lane_acc;

    logic signed [DATA_W-1:0]  in_buf  [N_IN];
    logic signed [DATA_W-1:0]  score_q [N_OUT];
    logic signed [DATA_W-1:0]  lane_score [LANES];

    assign hs = (state_q == StLoad) && s_valid && s_ready_q;

    // ROM data trails the address by a cycle, so the first product (and the
    // bias) arrive in MAC cycle 1 and the last one in DRAIN.
    assign lane_init = MULTI_IN ? (state_q == StMac && cnt_q == CNT_W'(1))
                                : (state_q == StDrain);
    assign lane_acc  = (state_q == StMac && cnt_q > CNT_W'(1)) ||
                       (state_q == StDrain && MULTI_IN);

    // Samples past the received length read as zero (short-frame padding).
    always_comb begin
        x_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (cnt_q == CNT_W'(i) && CNT_W'(i) < n_valid_q) begin
                x_sel = in_buf[i];
            end
        end
    end

    always_comb begin
        arg_val = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                arg_val = score_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs && !discard_q) begin
            for (int i = 0; i < N_IN; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    in_buf[i] <= s_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StStore) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (b_addr_q == BW'(i / LANES)) begin
                    score_q[i] <= lane_score[i % LANES];
                end
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        stream_fc_mac_lane #(
            .DATA_W   (DATA_W),
            .FRAC_BITS(FRAC_BITS),
            .ACC_W    (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_int_n),
            .init  (lane_init),
            .acc_en(lane_acc),
            .bias  (b_data[k*DATA_W +: DATA_W]),
            .x     (x_q),
            .w     (w_data[k*DATA_W +: DATA_W]),
            .score (lane_score[k])
        );
    end

    // b_addr doubles as the pass index.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            n_valid_q   <= '0;
            discard_q   <= 1'b0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_class_q   <= '0;
            frame_err_q <= 1'b0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
            x_q         <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q   <= StLoad;
                    s_ready_q <= 1'b1;
                    cnt_q     <= '0;
                end
                StLoad: begin
                    if (hs) begin
                        if (!discard_q) begin
                            if (s_last) begin
                                n_valid_q   <= cnt_q + CNT_W'(1);
                                frame_err_q <= (cnt_q != LAST_J);
                            end else if (cnt_q == LAST_J) begin
                                // Full buffer without s_last: swallow the rest of the frame.
                                n_valid_q   <= CNT_W'(N_IN);
                                discard_q   <= 1'b1;
                                frame_err_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        if (s_last) begin
                            state_q   <= StMac;
                            s_ready_q <= 1'b0;
                            discard_q <= 1'b0;
                            cnt_q     <= '0;
                            w_addr_q  <= '0;
                            b_addr_q  <= '0;
                        end
                    end
                end
                StMac: begin
                    x_q <= x_sel;
                    if (cnt_q == LAST_J) begin
                        state_q <= StDrain;
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                        w_addr_q <= w_addr_q + AW'(1);
                    end
                end
                StDrain: begin
                    state_q <= StStore;
                end
                StStore: begin
                    cnt_q <= '0;
                    if (b_addr_q == BW'(P - 1)) begin
                        state_q  <= StArgmax;
                        w_addr_q <= '0;
                        b_addr_q <= '0;
                    end else begin
                        state_q  <= StMac;
                        w_addr_q <= w_addr_q + AW'(1);
                        b_addr_q <= b_addr_q + BW'(1);
                    end
                end
                StArgmax: begin
                    if (cnt_q == CNT_W'(N_OUT)) begin
                        m_class_q <= best_idx_q;
                        m_valid_q <= 1'b1;
                        state_q   <= StOut;
                    end else begin
                        // Strict compare keeps the lowest index on ties.
                        if (cnt_q == '0 || arg_val > best_val_q) begin
                            best_val_q <= arg_val;
                            best_idx_q <= CW'(cnt_q);
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StOut: begin
                    if (m_ready) begin
                        m_valid_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StLoad;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_class   = m_class_q;
    assign frame_err = frame_err_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = b_addr_q;

endmodule
